// File: rtl/tl_input_cond.sv
// Traffic-light front end: 2-FF sync + debounce of chedo/den, change strobes, 1 Hz step and scan enables.
// Build with TL_FAST_SIM_EN defined to force short debounce/divider counts for full-controller sims.
module tl_input_cond #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic chedo_raw,
  input  logic den_raw,
  output logic chedo,
  output logic den,
  output logic mode_chg,
  output logic den_chg,
  output logic tick_1hz,
  output logic scan_tick
);

`ifdef TL_FAST_SIM_EN
  localparam int DEB_N  = 4;
  localparam int TICK_N = 16;
  localparam int SCAN_N = 2;
`else
  localparam int DEB_N  = DEB_CYCLES;
  localparam int TICK_N = TICK_DIV;
  localparam int SCAN_N = SCAN_DIV;
`endif

  localparam int DW = $clog2(DEB_N);
  localparam int TW = $clog2(TICK_N);
  localparam int SW = $clog2(SCAN_N);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_N - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_N - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_N - 1);
  // Bit 0 carries chedo (idles in auto), bit 1 carries den.
  localparam logic [1:0] IDLE = 2'b01;

  logic [1:0]    s1_q, s2_q;
  logic [1:0]    stb_q, stb_d;
  logic [1:0]    chg_q, chg_d;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          tick_q, tick_d;
  logic          scan_q, scan_d;
  logic          realign;

  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = '0;
      if (s2_q[i] != stb_q[i]) begin
        if (dcnt_q[i] == DEB_MAX) stb_d[i] = s2_q[i];
        else                      dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
    chg_d = stb_d ^ stb_q;

    // Entering auto restarts the second so the first auto step is full length.
    realign = ~stb_q[0] & stb_d[0];
    tick_d  = 1'b0;
    tcnt_d  = tcnt_q + 1'b1;
    if (realign) begin
      tcnt_d = '0;
    end else if (tcnt_q == TICK_MAX) begin
      tcnt_d = '0;
      tick_d = 1'b1;
    end

    scan_d = 1'b0;
    scnt_d = scnt_q + 1'b1;
    if (scnt_q == SCAN_MAX) begin
      scnt_d = '0;
      scan_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= IDLE;
      s2_q   <= IDLE;
      stb_q  <= IDLE;
      chg_q  <= '0;
      dcnt_q <= '{default: '0};
      tcnt_q <= '0;
      scnt_q <= '0;
      tick_q <= 1'b0;
      scan_q <= 1'b0;
    end else begin
      s1_q   <= {den_raw, chedo_raw};
      s2_q   <= s1_q;
      stb_q  <= stb_d;
      chg_q  <= chg_d;
      dcnt_q <= dcnt_d;
      tcnt_q <= tcnt_d;
      scnt_q <= scnt_d;
      tick_q <= tick_d;
      scan_q <= scan_d;
    end
  end

  assign chedo     = stb_q[0];
  assign den       = stb_q[1];
  assign mode_chg  = chg_q[0];
  assign den_chg   = chg_q[1];
  assign tick_1hz  = tick_q;
  assign scan_tick = scan_q;

endmodule

// File: tb/tb_tl_input_cond.sv
// Directed bench for tl_input_cond with a strobe scoreboard keyed on edge number.
module tb_tl_input_cond;
  logic clk = 1'b0;
  logic reset, chedo_raw, den_raw;
  logic chedo, den, mode_chg, den_chg, tick_1hz, scan_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // Expected edge numbers after which each strobe is high: 0 tick, 1 scan, 2 den_chg, 3 mode_chg.
  int    evq [4][$];
  string evname [4] = '{"tick_1hz", "scan_tick", "den_chg", "mode_chg"};

  tl_input_cond #(.DEB_CYCLES(4), .TICK_DIV(10), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .chedo_raw(chedo_raw), .den_raw(den_raw),
    .chedo(chedo), .den(den), .mode_chg(mode_chg), .den_chg(den_chg),
    .tick_1hz(tick_1hz), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at edge %0d: got %b want %b", tag, cyc, obs, exp);
    end
  endtask

  // Returns #1 after edge n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] obs;
      obs = {mode_chg, den_chg, scan_tick, tick_1hz};
      for (int k = 0; k < 4; k++) begin
        logic expb;
        expb = (evq[k].size() > 0) && (evq[k][0] == cyc);
        chk(evname[k], obs[k], expb);
        if (expb) void'(evq[k].pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; chedo_raw = 1'b1; den_raw = 1'b0;
    // Free-running strobes: ticks every 10 from release (edge 3), realigned at 53, restarted by reset at 71..73.
    foreach (evq[k]) evq[k].delete();
    evq[0] = '{13, 23, 33, 43, 63, 83, 93};
    for (int e = 7; e <= 67; e += 4) evq[1].push_back(e);
    for (int e = 77; e <= 97; e += 4) evq[1].push_back(e);
    mon_en = 1'b1;

    wait_edge(1);
    chk("rst_chedo", chedo, 1'b1);
    chk("rst_den", den, 1'b0);
    wait_edge(3);
    reset = 1'b0;

    // Glitch one cycle shorter than the debounce window.
    wait_edge(4);  den_raw = 1'b1;
    wait_edge(7);  den_raw = 0;
    wait_edge(12); chk("glitch_den", den, 1'b0);

    // den change first sampled at edge 20.
    wait_edge(19); den_raw = 1'b1; evq[2].push_back(25);
    wait_edge(24); chk("den_pre", den, 1'b0);
    wait_edge(25); chk("den_post", den, 1'b1);

    // Auto -> manual, no realign.
    wait_edge(29); chedo_raw = 1'b0; evq[3].push_back(35);
    wait_edge(34); chk("chedo_pre", chedo, 1'b1);
    wait_edge(35); chk("chedo_post", chedo, 1'b0);

    // Manual -> auto landing on the terminal count at edge 53.
    wait_edge(47); chedo_raw = 1'b1; evq[3].push_back(53);
    wait_edge(52); chk("auto_pre", chedo, 1'b0);
    wait_edge(53); chk("auto_post", chedo, 1'b1);

    // Both switches change on the same edge.
    wait_edge(59); chedo_raw = 1'b0; den_raw = 1'b0;
    evq[2].push_back(65); evq[3].push_back(65);
    wait_edge(64); chk("both_pre_chedo", chedo, 1'b1); chk("both_pre_den", den, 1'b1);
    wait_edge(65); chk("both_post_chedo", chedo, 1'b0); chk("both_post_den", den, 1'b0);

    // Reset with den debounce at 2 and tick count at 7 (after edge 70).
    wait_edge(66); den_raw = 1'b1;
    wait_edge(70); reset = 1'b1;
    wait_edge(71);
    chk("mid_rst_chedo", chedo, 1'b1);
    chk("mid_rst_den", den, 1'b0);
    chk("mid_rst_tick", tick_1hz, 1'b0);
    chk("mid_rst_scan", scan_tick, 1'b0);
    den_raw = 1'b0; chedo_raw = 1'b1;
    wait_edge(73); reset = 1'b0;
    wait_edge(80); chk("after_rst_den", den, 1'b0); chk("after_rst_chedo", chedo, 1'b1);

    wait_edge(100);
    mon_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      assert (evq[k].size() === 0) else begin
        n_bad++;
        $error("FAIL %s_left: got %0d pending want 0", evname[k], evq[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
